// File: rtl/izh_array_if.sv
// Bus bundle for izh_array: sweep handshake, per-channel inputs, spike and
// membrane readback. The neuron core takes the slave side.
interface izh_array_if #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 16,
   parameter int CUR_W    = 8
) ();
   localparam int SEL_W = $clog2(CHANNELS);

   logic                      step;
   logic [CHANNELS*CUR_W-1:0] current;
   logic [2*CHANNELS-1:0]     mode;
   logic [SEL_W-1:0]          rd_sel;
   logic                      busy;
   logic                      done;
   logic [CHANNELS-1:0]       spike;
   logic signed [WIDTH-1:0]   rd_v;

   modport master (
      output step, current, mode, rd_sel,
      input  busy, done, spike, rd_v
   );

   modport slave (
      input  step, current, mode, rd_sel,
      output busy, done, spike, rd_v
   );
endinterface

// File: rtl/izh_array.sv
// Time-multiplexed Izhikevich neuron array. One shared update datapath walks
// the channels one per clock after each accepted step; v/u live in small
// per-channel register banks and saturate to the signed WIDTH range.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for step; spike vector holds last sweep's result
//   S_RUN  | updating channel idx, one channel per clock
module izh_array #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 16,
   parameter int CUR_W    = 8,
   parameter int DT_SHIFT = 1,
   parameter int VPEAK    = 30
) (
   input logic         clk,
   input logic         reset,
   izh_array_if.slave  bus
);
   localparam int IW    = 2*WIDTH + 4;
   localparam int SEL_W = $clog2(CHANNELS);
   localparam int B_SH  = 2;

   localparam logic signed [WIDTH-1:0] V_RST = WIDTH'(-65);
   localparam logic signed [WIDTH-1:0] U_RST = WIDTH'(-17);

   localparam logic signed [IW-1:0] SAT_MAX = {{(IW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [IW-1:0] SAT_MIN = {{(IW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic signed [IW-1:0] K140    = IW'(140);
   localparam logic signed [IW-1:0] VPEAK_X = IW'(VPEAK);

   localparam logic signed [IW-1:0] C_RS = IW'(-65);
   localparam logic signed [IW-1:0] C_IB = IW'(-55);
   localparam logic signed [IW-1:0] C_CH = IW'(-50);
   localparam logic signed [IW-1:0] D_8  = IW'(8);
   localparam logic signed [IW-1:0] D_4  = IW'(4);
   localparam logic signed [IW-1:0] D_2  = IW'(2);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                    state;
   logic [SEL_W-1:0]          idx;
   logic [CHANNELS*CUR_W-1:0] cur_bank;
   logic [2*CHANNELS-1:0]     mode_bank;
   logic signed [WIDTH-1:0]   v_mem [CHANNELS];
   logic signed [WIDTH-1:0]   u_mem [CHANNELS];
   logic                      busy_q;
   logic                      done_q;
   logic [CHANNELS-1:0]       spike_q;
   logic signed [WIDTH-1:0]   rd_v_q;

   logic signed [WIDTH-1:0]   v_old;
   logic signed [WIDTH-1:0]   u_old;
   logic [CUR_W-1:0]          i_cur;
   logic [1:0]                m_cur;
   logic signed [IW-1:0]      vx;
   logic signed [IW-1:0]      ux;
   logic signed [IW-1:0]      ix;
   logic signed [IW-1:0]      sq;
   logic signed [IW-1:0]      dv;
   logic signed [IW-1:0]      v_nx;
   logic signed [IW-1:0]      u_nx;
   logic signed [IW-1:0]      u_fire;
   logic signed [IW-1:0]      c_val;
   logic signed [IW-1:0]      d_val;
   logic [2:0]                a_sh;
   logic                      fire;
   logic signed [WIDTH-1:0]   v_st;
   logic signed [WIDTH-1:0]   u_st;

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] x);
      if (x > SAT_MAX) return SAT_MAX[WIDTH-1:0];
      if (x < SAT_MIN) return SAT_MIN[WIDTH-1:0];
      return x[WIDTH-1:0];
   endfunction

   // Shared neuron update for the channel selected by idx, from its old v/u.
   always_comb begin
      v_old = v_mem[idx];
      u_old = u_mem[idx];
      i_cur = cur_bank[int'(idx)*CUR_W +: CUR_W];
      m_cur = mode_bank[int'(idx)*2 +: 2];

      vx = {{(IW-WIDTH){v_old[WIDTH-1]}}, v_old};
      ux = {{(IW-WIDTH){u_old[WIDTH-1]}}, u_old};
      ix = {{(IW-CUR_W){1'b0}}, i_cur};

      a_sh  = 3'd6;
      c_val = C_RS;
      d_val = D_8;
      case (m_cur)
         2'd0: begin a_sh = 3'd6; c_val = C_RS; d_val = D_8; end
         2'd1: begin a_sh = 3'd6; c_val = C_IB; d_val = D_4; end
         2'd2: begin a_sh = 3'd6; c_val = C_CH; d_val = D_2; end
         2'd3: begin a_sh = 3'd3; c_val = C_RS; d_val = D_2; end
      endcase

      sq     = vx * vx;
      dv     = (sq >>> 5) + vx + (vx <<< 2) + K140 - ux + ix;
      v_nx   = vx + (dv >>> DT_SHIFT);
      u_nx   = ux + (((vx >>> B_SH) - ux) >>> a_sh);
      u_fire = u_nx + d_val;
      fire   = (v_nx >= VPEAK_X);

      v_st = fire ? c_val[WIDTH-1:0] : sat(v_nx);
      u_st = fire ? sat(u_fire) : sat(u_nx);
   end

   // Sweep sequencer: snapshot inputs on step, write one channel per clock.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         idx       <= '0;
         cur_bank  <= '0;
         mode_bank <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         spike_q   <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            v_mem[k] <= V_RST;
            u_mem[k] <= U_RST;
         end
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.step) begin
                  cur_bank  <= bus.current;
                  mode_bank <= bus.mode;
                  spike_q   <= '0;
                  idx       <= '0;
                  busy_q    <= 1'b1;
                  state     <= S_RUN;
               end
            end
            S_RUN: begin
               v_mem[idx] <= v_st;
               u_mem[idx] <= u_st;
               if (fire) spike_q[idx] <= 1'b1;
               if (idx == SEL_W'(CHANNELS-1)) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= S_IDLE;
               end else begin
                  idx <= idx + SEL_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Registered membrane readback; out-of-range selects read as zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_v_q <= '0;
      end else if (int'(bus.rd_sel) < CHANNELS) begin
         rd_v_q <= v_mem[bus.rd_sel];
      end else begin
         rd_v_q <= '0;
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.spike = spike_q;
   assign bus.rd_v  = rd_v_q;
endmodule

// File: tb/tb_izh_array.sv
// Self-checking bench for izh_array: directed test-plan sweeps, randomized
// sweeps with ignored mid-sweep steps and back-to-back starts, a mid-sweep
// reset, and a long all-255 run, all against a per-sweep arithmetic model.
module tb_izh_array;
   localparam int CH   = 4;
   localparam int W    = 16;
   localparam int CW   = 8;
   localparam int DTS  = 1;
   localparam int VP   = 30;
   localparam int SW   = $clog2(CH);
   localparam int CURW = CH*CW;
   localparam int MW   = 2*CH;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   izh_array_if #(.CHANNELS(CH), .WIDTH(W), .CUR_W(CW)) bus ();

   izh_array #(
      .CHANNELS(CH), .WIDTH(W), .CUR_W(CW), .DT_SHIFT(DTS), .VPEAK(VP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   longint        mv [CH];
   longint        mu [CH];
   logic [CH-1:0] mspk;

   int a_tab [4] = '{6, 6, 6, 3};
   int c_tab [4] = '{-65, -55, -50, -65};
   int d_tab [4] = '{8, 4, 2, 2};

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint sat(input longint x);
      longint hi, lo;
      hi = (longint'(1) <<< (W-1)) - 1;
      lo = -(longint'(1) <<< (W-1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < CH; k++) begin
         mv[k] = -65;
         mu[k] = -17;
      end
      mspk = '0;
   endtask

   task automatic model_sweep(input logic [CURW-1:0] cur, input logic [MW-1:0] md);
      mspk = '0;
      for (int k = 0; k < CH; k++) begin
         longint v, u, iv, dv, vn, un;
         int     m;
         v  = mv[k];
         u  = mu[k];
         iv = cur[k*CW +: CW];
         m  = int'(md[2*k +: 2]);
         dv = ((v*v) >>> 5) + 5*v + 140 - u + iv;
         vn = v + (dv >>> DTS);
         un = u + (((v >>> 2) - u) >>> a_tab[m]);
         if (vn >= VP) begin
            mv[k]   = sat(c_tab[m]);
            mu[k]   = sat(un + d_tab[m]);
            mspk[k] = 1'b1;
         end else begin
            mv[k] = sat(vn);
            mu[k] = sat(un);
         end
      end
   endtask

   task automatic read_all(input string tag);
      for (int k = 0; k < CH; k++) begin
         @(negedge clk);
         bus.rd_sel = SW'(k);
         @(negedge clk);
         check($sformatf("%s_rd_v%0d", tag, k), bus.rd_v, mv[k]);
      end
   endtask

   // Runs one sweep; returns at the negedge inside the done cycle.
   // in_done: caller is already inside a done cycle, so drive step at once.
   task automatic sweep(input string tag, input logic [CURW-1:0] cur,
                        input logic [MW-1:0] md, input bit noise, input bit in_done);
      logic [CH-1:0] msk;
      if (!in_done) @(negedge clk);
      bus.step    = 1'b1;
      bus.current = cur;
      bus.mode    = md;
      @(posedge clk);
      model_sweep(cur, md);
      for (int j = 0; j < CH; j++) begin
         @(negedge clk);
         msk = CH'((1 << j) - 1);
         check($sformatf("%s_busy%0d", tag, j), bus.busy, 1);
         check($sformatf("%s_done%0d", tag, j), bus.done, 0);
         check($sformatf("%s_spk%0d", tag, j), bus.spike, mspk & msk);
         bus.step = noise && (j < CH-1);
         if (noise) begin
            bus.current = CURW'($urandom);
            bus.mode    = MW'($urandom);
         end
      end
      @(negedge clk);
      check({tag, "_busy_end"}, bus.busy, 0);
      check({tag, "_done_end"}, bus.done, 1);
      check({tag, "_spk_end"}, bus.spike, mspk);
   endtask

   initial begin
      int exp_dir [CH];
      bit in_done;
      logic [CURW-1:0] cur;
      logic [MW-1:0]   md;

      exp_dir     = '{-83, -65, -55, -65};
      reset       = 1'b1;
      bus.step    = 1'b0;
      bus.current = '0;
      bus.mode    = '0;
      bus.rd_sel  = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_spike", bus.spike, 0);
      check("rst_rd_v", bus.rd_v, 0);
      reset = 1'b0;
      read_all("init");

      // Directed: ch0 RS I=0, ch1 RS I=255, ch2 IB I=255, ch3 FS I=255.
      sweep("dir", {8'd255, 8'd255, 8'd255, 8'd0}, 8'b11_01_00_00, 1'b1, 1'b0);
      check("dir_spike_const", bus.spike, 4'b1110);
      @(negedge clk);
      check("dir_done_once", bus.done, 0);
      for (int k = 0; k < CH; k++) begin
         @(negedge clk);
         bus.rd_sel = SW'(k);
         @(negedge clk);
         check($sformatf("dir_v%0d", k), bus.rd_v, exp_dir[k]);
      end
      check("dir_spike_hold", bus.spike, 4'b1110);

      // Same again: exercises the hidden u values left by the first sweep.
      sweep("dir2", {8'd255, 8'd255, 8'd255, 8'd0}, 8'b11_01_00_00, 1'b0, 1'b0);
      @(negedge clk);
      read_all("dir2");

      // Randomized sweeps, some back-to-back, some with ignored steps.
      in_done = 1'b0;
      for (int i = 0; i < 24; i++) begin
         cur = CURW'($urandom);
         md  = MW'($urandom);
         sweep($sformatf("rnd%0d", i), cur, md, 1'($urandom_range(0, 1)), in_done);
         if ($urandom_range(0, 2) == 0) begin
            in_done = 1'b1;
         end else begin
            in_done = 1'b0;
            @(negedge clk);
            check($sformatf("rnd%0d_done_once", i), bus.done, 0);
            check($sformatf("rnd%0d_idle", i), bus.busy, 0);
            read_all($sformatf("rnd%0d", i));
         end
      end
      if (in_done) begin
         @(negedge clk);
         read_all("rnd_tail");
      end

      // Reset sampled at T0+2 in the middle of a sweep.
      @(negedge clk);
      bus.step    = 1'b1;
      bus.current = {CH{8'd255}};
      bus.mode    = '0;
      @(posedge clk);
      @(negedge clk);
      bus.step = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_busy", bus.busy, 0);
      check("mid_done", bus.done, 0);
      check("mid_spike", bus.spike, 0);
      check("mid_rd_v", bus.rd_v, 0);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("mid_nodone%0d", i), bus.done, 0);
      end
      read_all("mid");

      // Long drive at full current, chained, across random modes.
      in_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         sweep($sformatf("sat%0d", i), {CH{8'd255}}, MW'($urandom), 1'b0, in_done);
         in_done = 1'b1;
      end
      @(negedge clk);
      read_all("sat");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/izh_array.md
# izh_array

Time-multiplexed array of CHANNELS Izhikevich neurons sharing one update datapath, with per-channel firing mode and integer fixed-point state. Each `step` pulse advances every neuron by one time step, one channel per clock. It is the next-generation neuron core behind the Tiny Tapeout top level, replacing the single fixed-mode neuron. It drives a spike vector and a membrane-potential readback port.

## Interface
Parameters:
- CHANNELS, 4: number of neurons; must be ≥2.
- WIDTH, 16: signed width of v and u.
- CUR_W, 8: unsigned input-current width per channel.
- DT_SHIFT, 1: time-step scale; each increment is dv >>> DT_SHIFT.
- VPEAK, 30: spike threshold on v.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- step  in  1  start a sweep; sampled only when idle.
- current  in  CHANNELS*CUR_W  per-channel unsigned input; channel k occupies [k*CUR_W +: CUR_W].
- mode  in  2*CHANNELS  per-channel firing mode, 2 bits per channel.
- rd_sel  in  clog2(CHANNELS)  channel selected for readback.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep finishes.
- spike  out  CHANNELS  per-channel fired flags for the last sweep.
- rd_v  out  WIDTH  registered v of channel rd_sel.

## Operation
- Mode table (A = a-shift, B = b-shift, c, d):
  - 0 RS: A=6, B=2, c=-65, d=8.
  - 1 IB: A=6, B=2, c=-55, d=4.
  - 2 CH: A=6, B=2, c=-50, d=2.
  - 3 FS: A=3, B=2, c=-65, d=2.
- States: IDLE and RUN.
- IDLE → RUN when step=1:
  - Snapshot current and mode into internal banks.
  - Clear spike.
  - Set channel index to 0.
- RUN: update channel idx each cycle, using that channel's old v and u:
  - dv = ((v*v) >>> 5) + 5*v + 140 − u + I, with I zero-extended.
  - v' = v + (dv >>> DT_SHIFT).
  - u' = u + (((v >>> B) − u) >>> A).
  - If v' ≥ VPEAK: store v = c, u = u' + d, and set spike[idx].
  - Otherwise: store v', u'.
- Arithmetic and width rules:
  - Intermediates are 2*WIDTH+4 bits signed.
  - `>>>` is arithmetic (floor).
  - Stored v and u saturate to the signed WIDTH range.
- Index and exit: idx increments each cycle. After updating idx = CHANNELS−1, go to IDLE and pulse done.
- step while RUN is ignored; it is neither queued nor restarts the sweep.
- The current and mode inputs may change during RUN without effect, because the snapshots are used.
- rd_v reflects the stored v of rd_sel. If rd_sel ≥ CHANNELS, rd_v = 0.
- Reset, any cycle including mid-sweep:
  - All v = −65, all u = −17.
  - spike = 0, busy = 0, done = 0, rd_v = 0.
  - State goes to IDLE; banks are cleared to 0.

## Timing
- step is sampled at edge T0.
- busy = 1 from T0+1 through T0+CHANNELS.
- Channel k's state and spike bit are written at edge T0+1+k.
- done = 1 for exactly the cycle after edge T0+CHANNELS, with busy = 0 in that same cycle.
- The earliest next accepted step is in the done cycle, so back-to-back sweeps are allowed.
- spike bits hold until the next accepted step or reset.
- rd_v latency is 1 cycle from rd_sel, or from a v write.

## Test plan
- Reset, then read all channels → rd_v = −65 each; spike = 0; busy = 0.
- Resting sweep: RS, I=0 on ch0 → after done:
  - ch0 v = −83, u = −17.
  - spike[0] = 0.
- Firing sweep: RS, I=255 on ch1 → v' = 44 ≥ 30:
  - ch1 v = −65, u = −9.
  - spike[1] = 1, and spike[1] is set at edge T0+2.
- Mode check: IB, I=255 on ch2 → ch2 v = −55, u = −13. FS, I=255 on ch3 → ch3 v = −65, u = −15.
- Timing with CHANNELS=4:
  - busy high 4 cycles; done one cycle.
  - step asserted during busy is ignored, so a sweep count of 1 is required.
  - step in the done cycle is accepted.
- Reset asserted mid-sweep at T0+2:
  - The next cycle has busy = 0 and all state at reset values.
  - No done pulse follows.
  - Repeated I=255 sweeps never exceed the saturation limits.
